lfsr_divider: RTL

Programmable clock divider that consumes each new divisor seed from the upstream divisor-to-seed mapper and generates a divided clock. The divider uses an 8-bit XNOR LFSR as its half-period counter. On each rising edge of `done` it captures `dp`: `dp[8:1]` is the LFSR seed and `dp[0]` is the odd-divide flag. A new seed takes effect only at a half-period boundary, so the output frequency changes without glitches.

---
 rtl/lfsr_div_pkg.sv | 23 ++
 rtl/lfsr_divider_lfsr8.sv | 39 +++
 rtl/lfsr_divider.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_div_pkg.sv
// Shared definitions for the LFSR clock divider.
//   state_e          : divider FSM states
//   LFSR_LOCKUP      : XNOR LFSR lockup state, never a legal seed
//   TERMINAL_DEFAULT : LFSR state that ends a half-period
//   lfsr8_next       : one step of the 8-bit XNOR LFSR
package lfsr_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STRETCH = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [7:0] LFSR_LOCKUP      = 8'hFF;
  localparam logic [7:0] TERMINAL_DEFAULT = 8'h0F;

  // Taps 8,6,5,4 in XNOR form; matches the upstream mapper's sequence.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

endpackage

// File: rtl/lfsr_divider_lfsr8.sv
// 8-bit XNOR LFSR register.
//   clock, reset : system clock, asynchronous active-high reset (q -> 0)
//   load, seed   : load has priority and copies seed into the register
//   step         : advance one LFSR step when not loading
//   q            : current LFSR state
module lfsr8
  import lfsr_div_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr8_next(q_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_divider.sv
// Programmable clock divider driven by an 8-bit XNOR LFSR half-period counter.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high
//   enable   : synchronous run enable
//   dp       : {seed[7:0], odd} from the mapper, sampled on a done rising edge
//   done     : mapper valid level; its rising edge captures dp
//   clk_out  : divided clock (registered)
//   tick     : one-cycle pulse whenever clk_out changes
//   running  : high in RUN or STRETCH
//   seed_err : high in FAULT
module lfsr_divider
  import lfsr_div_pkg::*;
#(
  parameter logic [7:0] TERMINAL = TERMINAL_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] dp,
  input  logic       done,
  output logic       clk_out,
  output logic       tick,
  output logic       running,
  output logic       seed_err
);

  state_e     state_q, state_d;
  logic       clk_out_q, clk_out_d;
  logic       tick_q, running_q, seed_err_q;
  // seed_q/odd_q hold the most recent capture; act_* is what the counter uses.
  logic [7:0] seed_q, seed_d;
  logic [7:0] act_seed_q, act_seed_d;
  logic       odd_q, odd_d;
  logic       act_odd_q, act_odd_d;
  logic       pend_q, pend_d;
  logic       have_q, have_d;
  logic       done_q;
  // Set once done has been seen low after reset, so a done level that
  // straddles reset release is not mistaken for a fresh rising edge.
  logic       arm_q;

  logic       cap;
  logic [7:0] new_seed;
  logic       new_odd;
  logic       use_new;
  logic       boundary;
  logic       lfsr_load, lfsr_step;
  logic [7:0] lfsr_seed, lfsr_q;

  assign cap      = done & ~done_q & arm_q;
  // A capture on this very edge is newer than anything pending.
  assign new_seed = cap ? dp[8:1] : seed_q;
  assign new_odd  = cap ? dp[0]   : odd_q;
  assign use_new  = cap | pend_q;

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (lfsr_seed),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  always_comb begin
    state_d    = state_q;
    clk_out_d  = clk_out_q;
    seed_d     = seed_q;
    odd_d      = odd_q;
    pend_d     = pend_q;
    have_d     = have_q;
    act_seed_d = act_seed_q;
    act_odd_d  = act_odd_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    lfsr_seed  = act_seed_q;
    boundary   = 1'b0;

    if (cap) begin
      seed_d = dp[8:1];
      odd_d  = dp[0];
      pend_d = 1'b1;
      have_d = 1'b1;
    end

    if (!enable && state_q != ST_FAULT) begin
      state_d   = ST_IDLE;
      clk_out_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_FAULT: begin
          // IDLE also restarts from a retained seed after enable returns.
          if (cap || (state_q == ST_IDLE && have_q)) begin
            pend_d = 1'b0;
            if (new_seed == LFSR_LOCKUP) begin
              state_d = ST_FAULT;
            end else begin
              lfsr_load  = 1'b1;
              lfsr_seed  = new_seed;
              act_seed_d = new_seed;
              act_odd_d  = new_odd;
              state_d    = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (lfsr_q != TERMINAL) begin
            lfsr_step = 1'b1;
          end else if (clk_out_q && act_odd_q) begin
            // Odd divide: hold the high phase one extra cycle.
            state_d = ST_STRETCH;
          end else begin
            boundary = 1'b1;
          end
        end
        ST_STRETCH: begin
          boundary = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (boundary) begin
        if (use_new && new_seed == LFSR_LOCKUP) begin
          pend_d    = 1'b0;
          state_d   = ST_FAULT;
          clk_out_d = 1'b0;
        end else begin
          if (use_new) begin
            pend_d     = 1'b0;
            act_seed_d = new_seed;
            act_odd_d  = new_odd;
          end
          lfsr_load = 1'b1;
          lfsr_seed = use_new ? new_seed : act_seed_q;
          clk_out_d = ~clk_out_q;
          state_d   = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      seed_err_q <= 1'b0;
      seed_q     <= 8'h00;
      act_seed_q <= 8'h00;
      odd_q      <= 1'b0;
      act_odd_q  <= 1'b0;
      pend_q     <= 1'b0;
      have_q     <= 1'b0;
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= clk_out_d ^ clk_out_q;
      running_q  <= (state_d == ST_RUN) || (state_d == ST_STRETCH);
      seed_err_q <= (state_d == ST_FAULT);
      seed_q     <= seed_d;
      act_seed_q <= act_seed_d;
      odd_q      <= odd_d;
      act_odd_q  <= act_odd_d;
      pend_q     <= pend_d;
      have_q     <= have_d;
      done_q     <= done;
      arm_q      <= arm_q | ~done;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign running  = running_q;
  assign seed_err = seed_err_q;

endmodule
